// File: rtl/multicycle_sequencer_pkg.sv
// Shared types and encodings for the multi-cycle instruction sequencer:
// state and instruction-class enums, opcode constants and decode helpers.
package multicycle_pkg;

  typedef enum logic [2:0] {
    S_RST = 3'd0,
    S_IF  = 3'd1,
    S_ID  = 3'd2,
    S_EX  = 3'd3,
    S_MEM = 3'd4,
    S_WB  = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    C_ALU     = 3'd0,
    C_LOAD    = 3'd1,
    C_STORE   = 3'd2,
    C_BRANCH  = 3'd3,
    C_JUMP    = 3'd4,
    C_ILLEGAL = 3'd5
  } iclass_e;

  localparam logic [4:0] OP_LOAD  = 5'b01110;
  localparam logic [4:0] OP_STORE = 5'b01010;
  localparam logic [4:0] OP_BEQ   = 5'b01000;
  localparam logic [4:0] OP_J     = 5'b10000;

  localparam logic [1:0] PC_SRC_INC    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] COND_ALWAYS = 2'b00;
  localparam logic [1:0] COND_Z      = 2'b01;
  localparam logic [1:0] COND_NZ     = 2'b10;
  localparam logic [1:0] COND_NEVER  = 2'b11;

  // Exact opcodes are matched first; anything else with opcode[4:3]=00 is ALU.
  function automatic iclass_e decode_class(input logic [4:0] op);
    iclass_e c;
    if (op == OP_LOAD)           c = C_LOAD;
    else if (op == OP_STORE)     c = C_STORE;
    else if (op == OP_BEQ)       c = C_BRANCH;
    else if (op == OP_J)         c = C_JUMP;
    else if (op[4:3] == 2'b00)   c = C_ALU;
    else                         c = C_ILLEGAL;
    return c;
  endfunction

  function automatic logic pred_pass(input logic [1:0] cond, input logic z);
    logic p;
    case (cond)
      COND_ALWAYS: p = 1'b1;
      COND_Z:      p = z;
      COND_NZ:     p = ~z;
      COND_NEVER:  p = 1'b0;
      default:     p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Shared instruction/data memory handshake between the sequencer (master)
// and the memory (slave).
interface multicycle_sequencer_if;
  logic mem_req;
  logic mem_sel;
  logic mem_we;
  logic mem_ready;

  modport master (output mem_req, output mem_sel, output mem_we, input mem_ready);
  modport slave  (input mem_req, input mem_sel, input mem_we, output mem_ready);
endinterface

// File: rtl/multicycle_sequencer_mem_wait_timer.sv
// Counts memory wait cycles and flags the cycle in which the wait budget
// runs out. TIMEOUT = 0 never expires.
module mem_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic count_i,
  output logic expired_o
);

  localparam int W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [W-1:0] LAST = W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [W-1:0] count_q, count_d;

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  // Saturate so a disabled timeout cannot wrap into a false match.
  always_comb begin
    count_d = count_q;
    if (clear_i)                          count_d = '0;
    else if (count_i && (count_q != '1))  count_d = count_q + 1'b1;
  end

  // The current wait cycle is the TIMEOUT-th one when TIMEOUT-1 are already counted.
  assign expired_o = (TIMEOUT != 0) && count_i && (count_q == LAST);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer: owns the memory handshake and gates
// the PC, IR, register-file and memory write strobes per state.
module multicycle_sequencer
  import multicycle_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  opcode,
  input  logic [1:0]  condition,
  input  logic        zFlag,
  multicycle_sequencer_if.master bus,
  output logic [2:0]  state,
  output logic        ir_wr,
  output logic        pc_wr,
  output logic [1:0]  pc_src,
  output logic        reg_wr_en,
  output logic        retire,
  output logic        squash,
  output logic        bus_err,
  output logic        illegal
);

  state_e  state_q, state_d;
  iclass_e class_q, class_d;
  iclass_e id_class;
  logic    wait_count, wait_clear, wait_expired;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RST;
      class_q <= C_ALU;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
    end
  end

  assign state    = state_q;
  assign id_class = decode_class(opcode);

  assign wait_count = ((state_q == S_IF) || (state_q == S_MEM)) && !bus.mem_ready;
  // A timeout retry re-enters IF without a state change, so expiry also clears.
  assign wait_clear = ((state_d == S_IF) || (state_d == S_MEM)) &&
                      ((state_d != state_q) || wait_expired);

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (wait_clear),
    .count_i   (wait_count),
    .expired_o (wait_expired)
  );

  always_comb begin
    state_d      = state_q;
    class_d      = class_q;
    bus.mem_req  = 1'b0;
    bus.mem_sel  = 1'b0;
    bus.mem_we   = 1'b0;
    ir_wr        = 1'b0;
    pc_wr        = 1'b0;
    pc_src       = PC_SRC_INC;
    reg_wr_en    = 1'b0;
    retire       = 1'b0;
    squash       = 1'b0;
    bus_err      = 1'b0;
    illegal      = 1'b0;

    case (state_q)
      S_RST: state_d = S_IF;

      S_IF: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ready) begin
          ir_wr   = 1'b1;
          pc_wr   = 1'b1;
          state_d = S_ID;
        end else if (wait_expired) begin
          bus_err = 1'b1;
          state_d = S_IF;
        end
      end

      S_ID: begin
        class_d = id_class;
        if (!pred_pass(condition, zFlag)) begin
          squash  = 1'b1;
          state_d = S_IF;
        end else begin
          case (id_class)
            C_ALU, C_LOAD, C_STORE, C_BRANCH: state_d = S_EX;
            C_JUMP: begin
              pc_wr   = 1'b1;
              pc_src  = PC_SRC_JUMP;
              retire  = 1'b1;
              state_d = S_IF;
            end
            default: begin
              illegal = 1'b1;
              state_d = S_IF;
            end
          endcase
        end
      end

      S_EX: begin
        case (class_q)
          C_ALU:            state_d = S_WB;
          C_LOAD, C_STORE:  state_d = S_MEM;
          C_BRANCH: begin
            pc_wr   = zFlag;
            pc_src  = PC_SRC_BRANCH;
            retire  = 1'b1;
            state_d = S_IF;
          end
          default:          state_d = S_IF;
        endcase
      end

      S_MEM: begin
        bus.mem_req = 1'b1;
        bus.mem_sel = 1'b1;
        bus.mem_we  = (class_q == C_STORE);
        if (bus.mem_ready) begin
          if (class_q == C_STORE) begin
            retire  = 1'b1;
            state_d = S_IF;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_expired) begin
          bus_err = 1'b1;
          state_d = S_IF;
        end
      end

      S_WB: begin
        reg_wr_en = 1'b1;
        retire    = 1'b1;
        state_d   = S_IF;
      end

      default: state_d = S_RST;
    endcase

    // Nothing may be written once reset is seen, even in the cycle it arrives.
    if (reset) begin
      ir_wr      = 1'b0;
      pc_wr      = 1'b0;
      reg_wr_en  = 1'b0;
      bus.mem_we = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: per-instruction cycle traces are
// built from the instruction rules and compared against the DUT every cycle.
module tb_multicycle_sequencer;

  localparam int TO = 4;

  localparam logic [2:0] ST_RST = 3'd0;
  localparam logic [2:0] ST_IF  = 3'd1;
  localparam logic [2:0] ST_ID  = 3'd2;
  localparam logic [2:0] ST_EX  = 3'd3;
  localparam logic [2:0] ST_MEM = 3'd4;
  localparam logic [2:0] ST_WB  = 3'd5;

  localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BRANCH = 3, K_JUMP = 4, K_ILL = 5;

  typedef struct {
    logic       rst;
    logic [4:0] op;
    logic [1:0] cond;
    logic       z;
    logic       rdy;
    logic [2:0] st;
    logic       req, sel, we, irw, pcw;
    logic [1:0] src;
    logic       rwe, ret, sq, be, il;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] opcode;
  logic [1:0] condition;
  logic       zFlag;
  logic [2:0] state;
  logic       ir_wr, pc_wr, reg_wr_en, retire, squash, bus_err, illegal;
  logic [1:0] pc_src;

  multicycle_sequencer_if ifc ();

  multicycle_sequencer #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .condition (condition),
    .zFlag     (zFlag),
    .bus       (ifc.master),
    .state     (state),
    .ir_wr     (ir_wr),
    .pc_wr     (pc_wr),
    .pc_src    (pc_src),
    .reg_wr_en (reg_wr_en),
    .retire    (retire),
    .squash    (squash),
    .bus_err   (bus_err),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  vec_t vq[$];
  int   vecCount  = 0;
  int   missCount = 0;

  // Inputs outside ID/EX carry junk so the DUT must rely on what it latched.
  function automatic vec_t blank(input logic [2:0] st);
    vec_t v;
    v.rst = 1'b0; v.op = 5'b11111; v.cond = 2'b11; v.z = 1'b1; v.rdy = 1'b1;
    v.st = st; v.req = 1'b0; v.sel = 1'b0; v.we = 1'b0; v.irw = 1'b0; v.pcw = 1'b0;
    v.src = 2'b00; v.rwe = 1'b0; v.ret = 1'b0; v.sq = 1'b0; v.be = 1'b0; v.il = 1'b0;
    return v;
  endfunction

  function automatic bit passes(input logic [1:0] cond, input logic z);
    case (cond)
      2'b00:   return 1'b1;
      2'b01:   return z;
      2'b10:   return !z;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int kind(input logic [4:0] op);
    if (op == 5'b01110) return K_LOAD;
    if (op == 5'b01010) return K_STORE;
    if (op == 5'b01000) return K_BRANCH;
    if (op == 5'b10000) return K_JUMP;
    if (op[4:3] == 2'b00) return K_ALU;
    return K_ILL;
  endfunction

  task automatic fetch(input int waits);
    vec_t v;
    int cnt = 0;
    for (int w = 0; w < waits; w++) begin
      v = blank(ST_IF); v.req = 1'b1; v.rdy = 1'b0;
      cnt++;
      if (cnt == TO) begin v.be = 1'b1; cnt = 0; end
      vq.push_back(v);
    end
    v = blank(ST_IF); v.req = 1'b1; v.rdy = 1'b1; v.irw = 1'b1; v.pcw = 1'b1;
    vq.push_back(v);
  endtask

  task automatic writeBack();
    vec_t v;
    v = blank(ST_WB); v.rwe = 1'b1; v.ret = 1'b1;
    vq.push_back(v);
  endtask

  task automatic emitInstr(input logic [4:0] op, input logic [1:0] cond, input logic zId,
                           input logic zEx, input int ifW, input int memW);
    vec_t v;
    int k;
    k = kind(op);
    fetch(ifW);
    v = blank(ST_ID); v.op = op; v.cond = cond; v.z = zId;
    if (!passes(cond, zId)) begin v.sq = 1'b1; vq.push_back(v); return; end
    if (k == K_JUMP) begin
      v.pcw = 1'b1; v.src = 2'b10; v.ret = 1'b1; vq.push_back(v); return;
    end
    if (k == K_ILL) begin v.il = 1'b1; vq.push_back(v); return; end
    vq.push_back(v);
    v = blank(ST_EX); v.z = zEx;
    if (k == K_BRANCH) begin
      v.pcw = zEx; v.src = 2'b01; v.ret = 1'b1; vq.push_back(v); return;
    end
    vq.push_back(v);
    if (k == K_ALU) begin writeBack(); return; end
    for (int w = 0; w < memW; w++) begin
      v = blank(ST_MEM); v.req = 1'b1; v.sel = 1'b1; v.we = (k == K_STORE); v.rdy = 1'b0;
      if (w + 1 == TO) begin v.be = 1'b1; vq.push_back(v); return; end
      vq.push_back(v);
    end
    v = blank(ST_MEM); v.req = 1'b1; v.sel = 1'b1; v.we = (k == K_STORE); v.rdy = 1'b1;
    if (k == K_STORE) begin v.ret = 1'b1; vq.push_back(v); return; end
    vq.push_back(v);
    writeBack();
  endtask

  task automatic addInstr(input logic [4:0] op, input logic [1:0] cond, input logic zId,
                          input logic zEx, input int ifW, input int memW, output int cycles);
    int s;
    s = vq.size();
    emitInstr(op, cond, zId, zEx, ifW, memW);
    cycles = vq.size() - s;
  endtask

  task automatic pinLatency(input string name, input int got, input int req);
    vecCount++;
    if (got != req) begin
      missCount++;
      $display("[TB] FAIL latency_%s got %0d cycles required %0d", name, got, req);
    end
  endtask

  task automatic buildVectors();
    vec_t v;
    int n;
    v = blank(ST_RST); v.rst = 1'b1; vq.push_back(v);
    v = blank(ST_RST); vq.push_back(v);
    addInstr(5'b00010, 2'b00, 1'b0, 1'b0, 0, 0, n); pinLatency("alu", n, 4);
    addInstr(5'b01110, 2'b00, 1'b0, 1'b0, 0, 3, n); pinLatency("load_wait3", n, 8);
    addInstr(5'b00010, 2'b01, 1'b0, 1'b0, 0, 0, n); pinLatency("squash", n, 2);
    addInstr(5'b01000, 2'b00, 1'b0, 1'b1, 0, 0, n); pinLatency("beq_taken", n, 3);
    addInstr(5'b01000, 2'b00, 1'b1, 1'b0, 0, 0, n); pinLatency("beq_not", n, 3);
    addInstr(5'b01010, 2'b00, 1'b0, 1'b0, 0, 4, n); pinLatency("store_timeout", n, 7);
    addInstr(5'b01010, 2'b00, 1'b0, 1'b0, 0, 3, n); pinLatency("store_ready_late", n, 7);
    addInstr(5'b10000, 2'b01, 1'b1, 1'b0, 0, 0, n); pinLatency("jump", n, 2);
    addInstr(5'b11111, 2'b00, 1'b0, 1'b0, 0, 0, n); pinLatency("illegal", n, 2);
    addInstr(5'b00111, 2'b10, 1'b0, 1'b1, 5, 0, n); pinLatency("fetch_retry", n, 9);
    addInstr(5'b10000, 2'b11, 1'b0, 1'b0, 0, 0, n);
    addInstr(5'b00101, 2'b10, 1'b1, 1'b0, 0, 0, n);
    addInstr(5'b11000, 2'b01, 1'b1, 1'b0, 0, 0, n);
    addInstr(5'b01111, 2'b00, 1'b1, 1'b0, 1, 0, n);
    addInstr(5'b01110, 2'b00, 1'b0, 1'b0, 0, 0, n); pinLatency("load", n, 5);
    addInstr(5'b01010, 2'b00, 1'b0, 1'b0, 0, 0, n); pinLatency("store", n, 4);
    // STORE interrupted by reset on its third memory wait cycle.
    fetch(0);
    v = blank(ST_ID); v.op = 5'b01010; v.cond = 2'b00; v.z = 1'b0; vq.push_back(v);
    vq.push_back(blank(ST_EX));
    for (int w = 0; w < 2; w++) begin
      v = blank(ST_MEM); v.req = 1'b1; v.sel = 1'b1; v.we = 1'b1; v.rdy = 1'b0; vq.push_back(v);
    end
    v = blank(ST_MEM); v.rst = 1'b1; v.req = 1'b1; v.sel = 1'b1; v.rdy = 1'b0; vq.push_back(v);
    vq.push_back(blank(ST_RST));
    addInstr(5'b00010, 2'b00, 1'b0, 1'b0, 0, 0, n);
  endtask

  task automatic applyStimulus(input vec_t v);
    reset         = v.rst;
    opcode        = v.op;
    condition     = v.cond;
    zFlag         = v.z;
    ifc.mem_ready = v.rdy;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    logic [14:0] act, req;
    req = {v.st, v.req, v.sel, v.we, v.irw, v.pcw, v.src, v.rwe, v.ret, v.sq, v.be, v.il};
    act = {state, ifc.mem_req, ifc.mem_sel, ifc.mem_we, ir_wr, pc_wr, pc_src,
           reg_wr_en, retire, squash, bus_err, illegal};
    vecCount++;
    if (act !== req) begin
      missCount++;
      $display("[TB] FAIL cycle%0d st/req/sel/we/irw/pcw/src/rwe/ret/sq/be/il got %b required %b",
               idx, act, req);
    end
  endtask

  initial begin
    reset = 1'b1; opcode = 5'b0; condition = 2'b0; zFlag = 1'b0; ifc.mem_ready = 1'b0;
    buildVectors();
    repeat (2) @(posedge clk);
    #1;
    foreach (vq[i]) begin
      applyStimulus(vq[i]);
      @(negedge clk);
      checkOutput(vq[i], i);
      @(posedge clk);
      #1;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
